alu_cmd_tx: RTL and testbench
=============================

# alu_cmd_tx

Host-side command initiator for the UART ALU link. It accepts one ALU command (opcode plus up to `MAX_OPERANDS` 32-bit operands) over a valid/ready handshake. It frames the command as an ALU packet: a 4-byte header followed by little-endian operands. It then serializes the packet onto `txd_o` as 8N1 UART. It is the transmitting end toward `uart_alu`'s `rxd_i`, used in loopback benches and in an on-board self-test driver.

## Interface
- `CLK_FREQ_HZ`, default 16_000_000: `clk_i` frequency.
- `BAUD`, default 115_200: line rate. Bit period `DIV = CLK_FREQ_HZ / BAUD`, truncated; 138 at defaults.
- `MAX_OPERANDS`, default 4: operand slots on `operands_i`.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`  in  1  system clock.
  - `rst_ni`  in  1  asynchronous active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  block can accept a command.
- `cmd_opcode_i`  in  8  ALU opcode byte.
- `cmd_count_i`  in  `$clog2(MAX_OPERANDS+1)`  number of operands.
- `operands_i`  in  `32*MAX_OPERANDS`  operand k occupies bits `[32k+31:32k]`.
- `txd_o`  out  1  UART serial output; idle high.
- `busy_o`  out  1  packet in flight; equals `~cmd_ready_o`.

## Operation
- Accept a command when `cmd_valid_i && cmd_ready_o`. On that edge, capture the opcode, `n = min(cmd_count_i, MAX_OPERANDS)` and all operands. Later input changes have no effect.
- Packet byte order:
  - byte 0: opcode
  - byte 1: 0x00
  - byte 2: `len[7:0]`
  - byte 3: `len[15:8]`
  - then operand 0 through operand n-1, each least-significant byte first
- `len = 4 + 4*n`, computed as 16 bits; it counts the header.
- `n = 0` is legal and sends the header only.
- FSM states and transitions:
  - IDLE to HEADER on accept.
  - HEADER to PAYLOAD after byte 3 if `n > 0`.
  - HEADER to IDLE after byte 3 if `n == 0`.
  - PAYLOAD to IDLE after the last byte's stop bit.
- Byte index counter: 0..3 in HEADER, 0..4n-1 in PAYLOAD. Operand select is `idx[..:2]`; byte lane is `idx[1:0]`.
- Each byte is sent as 8N1: start bit 0, data bits LSB first, stop bit 1.
- Reset outputs: `txd_o=1`, `cmd_ready_o=1`, `busy_o=0`. The FSM resets to IDLE and all counters to 0.
- Reset asserted mid-packet: `txd_o` goes high asynchronously and the packet is abandoned. No partial byte resumes after reset release.

## Timing
- The start bit of byte 0 begins on the cycle after the accept edge.
- Every bit lasts exactly `DIV` cycles. A byte lasts `10*DIV` cycles.
- Bytes within a packet are contiguous: the next start bit directly follows the previous stop bit, with no idle gap.
- A packet lasts `(4 + 4n) * 10 * DIV` cycles.
- `cmd_ready_o` deasserts on the cycle after the accept edge. It reasserts on the cycle after the final stop bit's `DIV` cycles complete.
- The minimum inter-packet idle is 1 cycle plus handshake latency.
- `cmd_valid_i` asserted while busy is ignored and not queued. The command is taken when `cmd_ready_o` returns, if still valid.
- `txd_o` is driven from a flop; no combinational path from inputs to `txd_o`.

## Structure
- Shared package `uart_alu_pkg` holds:
  - the header layout constants: reserved byte value 0x00, header length 4;
  - the opcode constants, shared with `uart_alu`;
  - the FSM state typedef.
- Sub-module `uart_byte_tx`:
  - parameter `DIV`;
  - ports: `clk_i`, `rst_ni`, `valid_i`, `ready_o`, `data_i[7:0]`, `txd_o`;
  - contains the baud counter, bit counter and shift register.
- The packet FSM in `alu_cmd_tx` feeds it bytes.

## Test plan
- Reset, no command → `txd_o=1`, `cmd_ready_o=1`, `busy_o=0`; `txd_o` stays high for 10000 cycles.
- Opcode 0xEC, count 0 → bytes EC 00 04 00.
  - Start bit one cycle after accept.
  - Each bit 138 cycles; no inter-byte gaps.
  - `cmd_ready_o` high 5520 cycles after the first start bit begins.
- Opcode 0x10, count 2, operands 0x00000005 and 0x12345678 → bytes 10 00 0C 00 05 00 00 00 78 56 34 12.
- Count 7 with `MAX_OPERANDS=4` → len 0x0014; exactly 4 operands are sent (20 bytes total).
- Valid held during a packet, with opcode and operands changed mid-packet → first packet unchanged. The second command is accepted exactly one cycle after `cmd_ready_o` rises.
- `rst_ni` pulsed low during a payload byte, in a data bit equal to 0 → `txd_o=1` immediately. A following 0xEC command transmits cleanly, as checked by a reference UART receiver model.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU link: packet header layout, opcode map
// (common to uart_alu and alu_cmd_tx) and the command-initiator FSM state type.
package uart_alu_pkg;

  // Header: opcode, reserved, len[7:0], len[15:8]; len counts the header too.
  localparam logic [7:0]  HdrReserved = 8'h00;
  localparam int unsigned HdrLen      = 4;

  localparam logic [7:0] OpAdd  = 8'h10;
  localparam logic [7:0] OpSub  = 8'h11;
  localparam logic [7:0] OpMul  = 8'h12;
  localparam logic [7:0] OpAnd  = 8'h13;
  localparam logic [7:0] OpOr   = 8'h14;
  localparam logic [7:0] OpXor  = 8'h15;
  localparam logic [7:0] OpEcho = 8'hEC;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload
  } tx_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   valid_i       : byte offered on data_i
//   ready_o       : idle, or in the final cycle of the stop bit (allows
//                   back-to-back frames with no idle gap)
//   data_i        : byte to send, LSB first
//   txd_o         : serial line, idle high, registered
module uart_byte_tx #(
  parameter int unsigned DIV = 138
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       txd_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic            busy_q, busy_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [8:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            bit_end, frame_end;

  assign bit_end   = (baud_q == CntW'(DIV - 1));
  assign frame_end = busy_q && bit_end && (bit_q == 4'd9);
  assign ready_o   = !busy_q || frame_end;
  assign txd_o     = txd_q;

  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    if (valid_i && ready_o) begin
      // Start bit goes out on this edge; stop bit rides in shift_q[8].
      busy_d  = 1'b1;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = {1'b1, data_i};
      txd_d   = 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          txd_d  = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          txd_d   = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_d = baud_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      txd_q   <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/alu_cmd_tx.sv
// Host-side ALU command initiator: takes one command over valid/ready, frames
// it as header + little-endian operands and sends it as 8N1 UART on txd_o.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cmd_valid_i   : command present     cmd_ready_o : idle, can accept
//   cmd_opcode_i  : opcode byte         cmd_count_i : operand count (clamped)
//   operands_i    : operand k at [32k+31:32k]
//   txd_o         : UART output, idle high
//   busy_o        : packet in flight (~cmd_ready_o)
module alu_cmd_tx
  import uart_alu_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 16_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned MAX_OPERANDS = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic [7:0]                          cmd_opcode_i,
  input  logic [$clog2(MAX_OPERANDS+1)-1:0]   cmd_count_i,
  input  logic [32*MAX_OPERANDS-1:0]          operands_i,
  output logic                                txd_o,
  output logic                                busy_o
);

  localparam int unsigned DIV  = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CntW = $clog2(MAX_OPERANDS + 1);
  localparam int unsigned OpW  = 32 * MAX_OPERANDS;
  localparam int unsigned NumB = 4 * MAX_OPERANDS;
  localparam int unsigned IdxW = $clog2(NumB + 1);

  tx_state_e       state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] n_q, n_d;
  logic [OpW-1:0]  ops_q, ops_d;

  logic [CntW-1:0] n_in;
  logic [15:0]     len;
  logic [IdxW-1:0] pay_idx, pay_last;
  logic [7:0]      hdr_next, pay_byte, byte_data;
  logic            byte_valid, byte_ready;

  assign n_in     = (cmd_count_i > CntW'(MAX_OPERANDS)) ? CntW'(MAX_OPERANDS) : cmd_count_i;
  assign len      = 16'(HdrLen) + (16'(n_q) << 2);
  assign pay_last = IdxW'((32'(n_q) << 2) - 32'd1);
  // Index of the payload byte to load next: 0 when leaving the header.
  assign pay_idx  = (state_q == StPayload) ? idx_q + IdxW'(1) : '0;

  // idx_q names the byte currently on the wire, so the next header byte is idx_q+1.
  always_comb begin
    unique case (idx_q[1:0])
      2'd0:    hdr_next = HdrReserved;
      2'd1:    hdr_next = len[7:0];
      default: hdr_next = len[15:8];
    endcase
  end

  // Operands are packed little-endian, so payload byte i is simply byte i of
  // ops_q: operand idx[..:2], lane idx[1:0].
  always_comb begin
    pay_byte = 8'h00;
    for (int b = 0; b < NumB; b++) begin
      if (pay_idx == IdxW'(b)) pay_byte = ops_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    ops_d      = ops_q;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    unique case (state_q)
      StIdle: begin
        // The byte transmitter is always idle here; byte 0 goes straight into
        // its shifter on the accept edge, so the opcode needs no register.
        if (cmd_valid_i) begin
          byte_valid = 1'b1;
          byte_data  = cmd_opcode_i;
          n_d        = n_in;
          ops_d      = operands_i;
          idx_d      = '0;
          state_d    = StHeader;
        end
      end
      StHeader: begin
        if (byte_ready) begin
          if (idx_q != IdxW'(HdrLen - 1)) begin
            byte_valid = 1'b1;
            byte_data  = hdr_next;
            idx_d      = idx_q + IdxW'(1);
          end else if (n_q != '0) begin
            byte_valid = 1'b1;
            byte_data  = pay_byte;
            idx_d      = '0;
            state_d    = StPayload;
          end else begin
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end
      StPayload: begin
        if (byte_ready) begin
          if (idx_q == pay_last) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            byte_valid = 1'b1;
            byte_data  = pay_byte;
            idx_d      = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      ops_q   <= ops_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = ~cmd_ready_o;

  uart_byte_tx #(
    .DIV(DIV)
  ) u_byte_tx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(byte_valid),
    .ready_o(byte_ready),
    .data_i (byte_data),
    .txd_o  (txd_o)
  );

endmodule

// File: tb/tb_alu_cmd_tx.sv
// Directed bench for alu_cmd_tx at default clock/baud (138 cycles per bit).
module tb_alu_cmd_tx;

  localparam int unsigned Div = 138;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode = 8'h00;
  logic [2:0]   cmd_count = 3'd0;
  logic [127:0] operands = '0;
  logic         txd;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_tx #(
    .CLK_FREQ_HZ (16_000_000),
    .BAUD        (115_200),
    .MAX_OPERANDS(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_opcode_i(cmd_opcode),
    .cmd_count_i (cmd_count),
    .operands_i  (operands),
    .txd_o       (txd),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [7:0] op, input logic [2:0] cnt, input logic [127:0] ops);
    cmd_opcode = op;
    cmd_count  = cnt;
    operands   = ops;
    cmd_valid  = 1'b1;
  endtask

  // Cycle-exact check of one packet against exp_q. The first sample is the
  // cycle after the accept edge; the final sample is (bytes*10*Div) later.
  task automatic expect_packet(input string tag, input bit release_valid, input bit mutate);
    int         bad;
    bit         first;
    logic [7:0] cur, obs;
    logic       exp_bit;
    bad   = 0;
    first = 1'b1;
    foreach (exp_q[b]) begin
      cur = exp_q[b];
      obs = 8'h00;
      for (int k = 0; k < 10; k++) begin
        exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur[k-1];
        for (int c = 0; c < int'(Div); c++) begin
          @(negedge clk);
          if (first) begin
            first = 1'b0;
            if (release_valid) cmd_valid = 1'b0;
            check_eq({tag, " ready drop"}, 32'(cmd_ready), 32'd0);
            check_eq({tag, " start bit"}, 32'(txd), 32'd0);
          end
          if (mutate && b == 2 && k == 0 && c == 0) begin
            cmd_opcode = 8'h11;
            cmd_count  = 3'd0;
            operands   = {4{32'hDEADBEEF}};
          end
          if (txd !== exp_bit || cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
          if (k >= 1 && k <= 8 && c == int'(Div / 2)) obs[k-1] = txd;
        end
      end
      check_eq($sformatf("%s byte%0d", tag, b), 32'(obs), 32'(cur));
    end
    check_eq({tag, " wave bad cycles"}, bad, 0);
    @(negedge clk);
    check_eq({tag, " ready back"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, " busy back"}, 32'(busy), 32'd0);
    check_eq({tag, " txd idle"}, 32'(txd), 32'd1);
  endtask

  // Reference mid-bit-sampling UART receiver, checks exp_q.
  task automatic uart_rx_check(input string tag);
    bit         found;
    logic [7:0] got;
    logic       start_mid, stop_bit;
    foreach (exp_q[b]) begin
      found = 1'b0;
      for (int w = 0; w < int'(4 * Div) && !found; w++) begin
        @(negedge clk);
        if (txd === 1'b0) found = 1'b1;
      end
      check_eq($sformatf("%s start%0d seen", tag, b), 32'(found), 32'd1);
      repeat (Div / 2) @(negedge clk);
      start_mid = txd;
      for (int k = 0; k < 8; k++) begin
        repeat (Div) @(negedge clk);
        got[k] = txd;
      end
      repeat (Div) @(negedge clk);
      stop_bit = txd;
      check_eq($sformatf("%s start%0d mid", tag, b), 32'(start_mid), 32'd0);
      check_eq($sformatf("%s rx byte%0d", tag, b), 32'(got), 32'(exp_q[b]));
      check_eq($sformatf("%s stop%0d", tag, b), 32'(stop_bit), 32'd1);
    end
    repeat (Div / 2) @(negedge clk);
    check_eq({tag, " ready back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int low;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset txd", 32'(txd), 32'd1);
    check_eq("reset ready", 32'(cmd_ready), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    low = 0;
    repeat (10000) begin
      @(negedge clk);
      if (txd !== 1'b1) low++;
    end
    check_eq("idle txd low cycles", low, 0);

    // Header-only packet, valid held; inputs change mid-packet and the
    // changed command must go out one cycle after ready returns.
    drive_cmd(8'hEC, 3'd0, '0);
    exp_q = '{8'hEC, 8'h00, 8'h04, 8'h00};
    expect_packet("held1", 1'b0, 1'b1);
    exp_q = '{8'h11, 8'h00, 8'h04, 8'h00};
    expect_packet("held2", 1'b1, 1'b0);

    drive_cmd(8'h10, 3'd2, {64'h0, 32'h12345678, 32'h00000005});
    exp_q = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12};
    expect_packet("two ops", 1'b1, 1'b0);

    // Count 7 clamps to 4 operands.
    drive_cmd(8'h12, 3'd7, {32'hCAFEF00D, 32'h0BADBEEF, 32'h87654321, 32'h01020304});
    exp_q = '{8'h12, 8'h00, 8'h14, 8'h00,
              8'h04, 8'h03, 8'h02, 8'h01, 8'h21, 8'h43, 8'h65, 8'h87,
              8'hEF, 8'hBE, 8'hAD, 8'h0B, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    expect_packet("clamp", 1'b1, 1'b0);

    // Reset in payload byte 0, data bit 1 (a 0 bit of 0xF0).
    drive_cmd(8'h13, 3'd1, {96'h0, 32'h000000F0});
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rst pkt start", 32'(txd), 32'd0);
    repeat (4 * 10 * Div + 2 * Div + Div / 2) @(negedge clk);
    check_eq("rst pre data bit", 32'(txd), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst async txd", 32'(txd), 32'd1);
    check_eq("rst async ready", 32'(cmd_ready), 32'd1);
    check_eq("rst async busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    low = 0;
    repeat (20 * Div) begin
      @(negedge clk);
      if (txd !== 1'b1) low++;
    end
    check_eq("post-rst quiet low cycles", low, 0);
    check_eq("post-rst ready", 32'(cmd_ready), 32'd1);

    drive_cmd(8'hEC, 3'd0, '0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    exp_q = '{8'hEC, 8'h00, 8'h04, 8'h00};
    uart_rx_check("post-rst rx");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
